// File: rtl/spi_regfile_peripheral.sv
// SPI mode-0 peripheral writing a small control register bank, with frame/address error pulses.
// Optional CIPO register readback is built when SPI_READBACK_EN is defined.
module spi_regfile_peripheral #(
    parameter int                NUM_REGS  = 5,
    parameter int                DATA_W    = 8,
    parameter int                ADDR_W    = 7,
    parameter logic [DATA_W-1:0] REG_RESET = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       nCS,
    input  logic                       SCLK,
    input  logic                       COPI,
    output logic                       CIPO,
    output logic                       cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0] regs_out,
    output logic                       wr_strobe,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic                       err_frame,
    output logic                       err_addr,
    output logic [7:0]                 frame_cnt
);

    localparam int FRAME_W = 1 + ADDR_W + DATA_W;
    localparam int CNT_W   = $clog2(FRAME_W + 1);
    localparam logic [CNT_W-1:0] FULL    = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0] ADDR_LD = CNT_W'(ADDR_W);
    localparam logic [CNT_W-1:0] DATA_PH = CNT_W'(1 + ADDR_W);

    typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;

    state_t             state;
    logic [2:0]         ncs_q;
    logic [2:0]         sclk_q;
    logic [1:0]         copi_q;
    logic [CNT_W-1:0]   bit_cnt;
    logic [FRAME_W-1:0] sh;
    logic               overrun;
    logic               start_pend;
    logic [DATA_W-1:0]  regs [NUM_REGS];

    logic               ncs_fall;
    logic               ncs_rise;
    logic               sclk_rise;
    logic               sclk_fall;
    logic [FRAME_W-1:0] nx_sh;
    logic               f_rw;
    logic [ADDR_W-1:0]  f_addr;
    logic [DATA_W-1:0]  f_data;
    logic               f_addr_ok;

    assign ncs_fall  = ~ncs_q[1] & ncs_q[2];
    assign ncs_rise  = ncs_q[1] & ~ncs_q[2];
    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign sclk_fall = ~sclk_q[1] & sclk_q[2];
    assign nx_sh     = {sh[FRAME_W-2:0], copi_q[1]};

    assign f_rw      = sh[FRAME_W-1];
    assign f_addr    = sh[DATA_W +: ADDR_W];
    assign f_data    = sh[DATA_W-1:0];
    assign f_addr_ok = int'(f_addr) < NUM_REGS;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
        assign regs_out[g*DATA_W +: DATA_W] = regs[g];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ncs_q  <= 3'b111;
            sclk_q <= 3'b000;
            copi_q <= 2'b00;
        end else begin
            ncs_q  <= {ncs_q[1:0], nCS};
            sclk_q <= {sclk_q[1:0], SCLK};
            copi_q <= {copi_q[0], COPI};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            sh         <= '0;
            overrun    <= 1'b0;
            start_pend <= 1'b0;
            wr_strobe  <= 1'b0;
            wr_addr    <= '0;
            err_frame  <= 1'b0;
            err_addr   <= 1'b0;
            frame_cnt  <= 8'd0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= REG_RESET;
        end else begin
            wr_strobe <= 1'b0;
            err_frame <= 1'b0;
            err_addr  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (ncs_fall || start_pend) begin
                        state      <= RECV;
                        bit_cnt    <= '0;
                        sh         <= '0;
                        overrun    <= 1'b0;
                        start_pend <= 1'b0;
                    end
                end
                RECV: begin
                    if (ncs_rise) begin
                        state <= CHECK;
                    end else if (sclk_rise) begin
                        if (bit_cnt < FULL) begin
                            sh      <= nx_sh;
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end else begin
                            overrun <= 1'b1;
                        end
                    end
                end
                CHECK: begin
                    state      <= IDLE;
                    // a frame starting right now is replayed from IDLE
                    start_pend <= ncs_fall;
                    if (bit_cnt != FULL || overrun) begin
                        err_frame <= 1'b1;
                    end else if (f_rw && f_addr_ok) begin
                        for (int i = 0; i < NUM_REGS; i++)
                            if (int'(f_addr) == i) regs[i] <= f_data;
                        wr_strobe <= 1'b1;
                        wr_addr   <= f_addr;
                        frame_cnt <= frame_cnt + 8'd1;
                    end else if (f_rw) begin
                        err_addr <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SPI_READBACK_EN
    logic              rd_phase;
    logic [DATA_W-1:0] tx_sr;
    logic [DATA_W-1:0] rd_word;

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++)
            if (int'(nx_sh[ADDR_W-1:0]) == i) rd_word = regs[i];
    end

    // load on the rise that completes the address; shift on falls after the first data rise
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_phase <= 1'b0;
            tx_sr    <= '0;
        end else if (state != RECV) begin
            rd_phase <= 1'b0;
            tx_sr    <= '0;
        end else if (!ncs_rise) begin
            if (sclk_rise && bit_cnt == ADDR_LD && !nx_sh[ADDR_W]) begin
                rd_phase <= 1'b1;
                tx_sr    <= rd_word;
            end else if (sclk_fall && rd_phase && bit_cnt > DATA_PH) begin
                tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
            end
        end
    end

    assign cipo_oe = (state == RECV) & ~ncs_q[1];
    assign CIPO    = rd_phase & tx_sr[DATA_W-1];
`else
    assign cipo_oe = 1'b0;
    assign CIPO    = 1'b0;
`endif

endmodule

// File: tb/tb_spi_regfile_peripheral.sv
// Directed and random SPI frames checked against a register-bank model.
// Readback checks follow SPI_READBACK_EN.
module tb_spi_regfile_peripheral;

    localparam int NR = 5;
`ifdef SPI_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        nCS = 1'b1;
    logic        SCLK = 1'b0;
    logic        COPI = 1'b0;
    logic        CIPO;
    logic        cipo_oe;
    logic [39:0] regs_out;
    logic        wr_strobe;
    logic [6:0]  wr_addr;
    logic        err_frame;
    logic        err_addr;
    logic [7:0]  frame_cnt;

    int checks = 0;
    int failures = 0;
    logic [7:0] model [NR];
    logic [7:0] model_cnt;
    logic [6:0] model_wa;

    spi_regfile_peripheral dut (
        .clk(clk), .rst(rst), .nCS(nCS), .SCLK(SCLK), .COPI(COPI),
        .CIPO(CIPO), .cipo_oe(cipo_oe), .regs_out(regs_out),
        .wr_strobe(wr_strobe), .wr_addr(wr_addr), .err_frame(err_frame),
        .err_addr(err_addr), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [39:0] model_flat();
        logic [39:0] f;
        for (int i = 0; i < NR; i++) f[i*8 +: 8] = model[i];
        return f;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NR; i++) model[i] = 8'h00;
        model_cnt = 8'd0;
        model_wa = 7'd0;
    endtask

    task automatic clock_bits(input logic [31:0] bits, input int n, input int nb,
                              inout logic [31:0] cap, inout bit oe_and, inout bit oe_or);
        for (int i = 0; i < nb; i++) begin
            COPI = bits[n-1-i];
            tick(8);
            SCLK = 1'b1;
            cap = {cap[30:0], CIPO};
            oe_and = oe_and & cipo_oe;
            oe_or = oe_or | cipo_oe;
            tick(8);
            SCLK = 1'b0;
        end
    endtask

    task automatic watch(output int ns, output int nf, output int na, output logic [6:0] wa);
        ns = 0; nf = 0; na = 0; wa = 'x;
        repeat (14) begin
            tick(1);
            if (wr_strobe) begin ns++; wa = wr_addr; end
            if (err_frame) nf++;
            if (err_addr) na++;
        end
    endtask

    task automatic run_frame(input string tag, input logic [31:0] bits, input int n);
        logic [31:0] cap;
        bit oe_and, oe_or;
        int ns, nf, na;
        logic [6:0] wa;
        logic rw;
        logic [6:0] addr;
        logic [7:0] data;
        int es, ef, ea;
        logic [15:0] exp_cap;

        rw = bits[15];
        addr = bits[14:8];
        data = bits[7:0];
        es = 0; ef = 0; ea = 0;
        if (n != 16) ef = 1;
        else if (rw && addr < NR) es = 1;
        else if (rw) ea = 1;
        exp_cap = 16'h0000;
        if (RB && n == 16 && !rw && addr < NR) exp_cap = {8'h00, model[addr]};

        cap = '0; oe_and = 1'b1; oe_or = 1'b0;
        nCS = 1'b0;
        tick(6);
        clock_bits(bits, n, n, cap, oe_and, oe_or);
        tick(6);
        nCS = 1'b1;
        watch(ns, nf, na, wa);

        if (es == 1) begin
            model[addr] = data;
            model_cnt = model_cnt + 8'd1;
            model_wa = addr;
        end

        chk({tag, ":strobe"}, 64'(ns), 64'(es));
        chk({tag, ":err_frame"}, 64'(nf), 64'(ef));
        chk({tag, ":err_addr"}, 64'(na), 64'(ea));
        if (es == 1) chk({tag, ":wr_addr_pulse"}, 64'(wa), 64'(addr));
        chk({tag, ":wr_addr"}, 64'(wr_addr), 64'(model_wa));
        chk({tag, ":regs"}, 64'(regs_out), 64'(model_flat()));
        chk({tag, ":frame_cnt"}, 64'(frame_cnt), 64'(model_cnt));
        chk({tag, ":oe_and"}, 64'(oe_and), 64'(RB));
        chk({tag, ":oe_or"}, 64'(oe_or), 64'(RB));
        if (!RB) chk({tag, ":cipo"}, 64'(cap), 64'h0);
        else if (n == 16) chk({tag, ":cipo"}, 64'(cap[15:0]), 64'(exp_cap));
    endtask

    initial begin
        logic [31:0] bits;
        logic [31:0] cap;
        bit oe_and, oe_or;
        int ns, nf, na, n;
        logic [6:0] wa;
        logic [15:0] fr;

        model_reset();
        tick(5);
        rst = 1'b0;
        tick(2);
        chk("rst:regs", 64'(regs_out), 64'h0);
        chk("rst:frame_cnt", 64'(frame_cnt), 64'h0);
        chk("rst:wr_addr", 64'(wr_addr), 64'h0);
        chk("rst:pulses", 64'({wr_strobe, err_frame, err_addr}), 64'h0);
        chk("rst:cipo", 64'({CIPO, cipo_oe}), 64'h0);

        run_frame("wr4", 32'h8455, 16);
        run_frame("short15", 32'h8455 >> 1, 15);
        run_frame("badaddr", 32'h89AA, 16);
        run_frame("rd4", 32'h0400, 16);
        run_frame("long20", {12'h0, 16'h81FF, 4'hA}, 20);

        for (int k = 0; k < 24; k++) begin
            fr = {1'($urandom_range(0, 1)), 7'($urandom_range(0, 7)), 8'($urandom)};
            case ($urandom_range(0, 5))
                0: n = 12;
                1: n = 18;
                default: n = 16;
            endcase
            bits = (n == 16) ? {16'h0, fr} : ($urandom & ((32'd1 << n) - 1));
            run_frame($sformatf("rnd%0d", k), bits, n);
        end

        // reset in the middle of a frame
        bits = 32'h83C3;
        cap = '0; oe_and = 1'b1; oe_or = 1'b0;
        nCS = 1'b0;
        tick(6);
        clock_bits(bits, 16, 10, cap, oe_and, oe_or);
        rst = 1'b1;
        nCS = 1'b1;
        SCLK = 1'b0;
        tick(4);
        rst = 1'b0;
        model_reset();
        watch(ns, nf, na, wa);
        chk("midrst:pulses", 64'(ns + nf + na), 64'h0);
        chk("midrst:regs", 64'(regs_out), 64'(model_flat()));
        chk("midrst:frame_cnt", 64'(frame_cnt), 64'(model_cnt));
        run_frame("after_rst", 32'h83C3, 16);
        chk("after_rst:reg3", 64'(regs_out[31:24]), 64'hC3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_regfile_peripheral.md
Name: spi_regfile_peripheral

Overview:
Parametrised SPI mode-0 peripheral driving a configurable bank of control registers, e.g. output enables, PWM enables and duty cycle. Supports writes and, optionally, register readback on CIPO. Adds frame-length and address error reporting and a good-frame counter. Sits between the chip-level SPI pins and the PWM/output-enable logic; all SPI inputs are oversampled in the system clock domain.

Parameters:
NUM_REGS, 5, number of implemented registers (addresses 0..NUM_REGS-1)
DATA_W, 8, register/data-field width in bits
ADDR_W, 7, address-field width; FRAME_W = 1 + ADDR_W + DATA_W
REG_RESET, 0, reset value of every register (DATA_W bits)

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
nCS  input  1  SPI chip select, active low, asynchronous
SCLK  input  1  SPI clock, asynchronous, max freq clk/8
COPI  input  1  SPI controller-out data, MSB first
CIPO  output  1  SPI peripheral-out data (readback)
cipo_oe  output  1  CIPO output enable
regs_out  output  NUM_REGS*DATA_W  flattened register bank, reg n at [n*DATA_W +: DATA_W]
wr_strobe  output  1  one-cycle pulse on each register commit
wr_addr  output  ADDR_W  address of last commit, valid with wr_strobe
err_frame  output  1  one-cycle pulse: frame ended with bit count != FRAME_W
err_addr  output  1  one-cycle pulse: complete write to address >= NUM_REGS
frame_cnt  output  8  count of good committed writes, wraps 255->0

Behaviour:
- Reset (rst high on a clk edge): all registers = REG_RESET; CIPO=0, cipo_oe=0, wr_strobe=0, err_*=0, wr_addr=0, frame_cnt=0; sync chain nCS=1, SCLK=0, COPI=0; bit_cnt=0; state IDLE. Reset mid-frame aborts the frame with no commit and no error pulse.
- Synchronisers: nCS, SCLK, COPI each pass through 2 flops plus a third history flop. sclk_rise = s2 & ~s3; sclk_fall = ~s2 & s3; ncs_fall/ncs_rise likewise.
- Frame format, MSB first: bit FRAME_W-1 = R/W (1 = write), next ADDR_W bits = address, low DATA_W bits = data.
- FSM IDLE: on ncs_fall -> RECV, bit_cnt=0, shift reg cleared.
- FSM RECV: on sclk_rise with bit_cnt < FRAME_W, shift in COPI(sync) and increment bit_cnt. Edges beyond FRAME_W are not shifted; an overrun flag is set. On ncs_rise -> CHECK; any SCLK edge in the same cycle is ignored.
- FSM CHECK (1 cycle) -> IDLE:
  - bit_cnt==FRAME_W, no overrun, write, addr<NUM_REGS: reg[addr]<=data; wr_strobe=1; wr_addr=addr; frame_cnt+1.
  - write with addr>=NUM_REGS: err_addr=1; no change.
  - bit_cnt!=FRAME_W or overrun: err_frame=1; no change.
  - Complete read frame: no commit, no error.
- Latency: register update and wr_strobe appear 1 clk after the cycle ncs_rise is detected, i.e. about 4 clk after the nCS pin rises.
- Outputs wr_strobe, err_frame and err_addr are registered and mutually exclusive.
- ncs_fall while in CHECK is held off one cycle: the new frame starts from IDLE next cycle, and no SCLK edge is lost at the clk/8 limit.

Optional Feature:
SPI_READBACK_EN
- Defined: cipo_oe = 1 while synced nCS is low in RECV. When bit_cnt reaches 1+ADDR_W with R/W=0, tx shift reg loads reg[addr], or 0 if addr>=NUM_REGS. CIPO = tx MSB, shifted on each sclk_fall during the data phase; CIPO=0 outside the data phase. Writes never drive read data.
- Undefined: CIPO and cipo_oe are constant 0; read frames are received, counted as complete, and ignored.

Test Plan:
- Default params, write frame 0x8455 -> one cycle later regs_out[39:32]=0x55, wr_strobe one pulse, wr_addr=4, frame_cnt=1.
- 15-bit frame 0x8455>>1 -> err_frame pulse, no reg change, frame_cnt unchanged.
- Write 0x89AA (addr 9) -> err_addr pulse, all regs unchanged.
- With SPI_READBACK_EN, after reg4=0x55, read 0x0400 -> CIPO bits 0,1,0,1,0,1,0,1 sampled on the last 8 SCLK rises; cipo_oe high for the frame.
- 20-bit frame with first 16 bits 0x81FF -> err_frame, reg1 unchanged.
- Assert rst after 10 bits of 0x83C3 -> all regs = REG_RESET, no pulses. A following full 0x83C3 frame -> reg3=0xC3.
